// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter.
// Contents: arbiter state enum and the saturation limit of the contention counter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    localparam int unsigned CntW    = 16;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset, clears the count
//   inc_i  - increment enable for this cycle
//   cnt_o  - current count, holds at Max once reached
module sat_counter #(
    parameter int unsigned     Width = 16,
    parameter logic [Width-1:0] Max  = {Width{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != Max)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and load/store.
// Data has fixed priority over fetch; one transaction outstanding at a time.
// Ports:
//   clk, rst                       - clock / asynchronous active-high reset
//   if_req, if_addr                - fetch request (held until if_valid)
//   if_rdata, if_valid             - fetched word, one-cycle completion pulse
//   d_req, d_we, d_addr, d_wdata   - load/store request (held until d_valid)
//   d_rdata, d_valid               - load data, one-cycle completion pulse
//   m_req, m_we, m_addr, m_wdata   - registered memory request
//   m_rdata, m_ack                 - memory response (latency >= 1 cycle)
//   stall_f, stall_m               - stall requests to the hazard unit
//   contention_cnt                 - saturating count of fetch cycles lost to data
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              stall_f,
    output logic              stall_m,
    output logic [15:0]       contention_cnt
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              m_req_q, m_req_d;
    logic              if_valid_q, if_valid_d;
    logic              d_valid_q, d_valid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_pend, d_pend;
    logic              cont_inc;

    // A request still high in its own valid cycle is the one just served, not a new one;
    // granting on it would repeat the access.
    assign if_pend = if_req & ~if_valid_q;
    assign d_pend  = d_req & ~d_valid_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        m_req_d    = m_req_q;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (d_pend) begin
                    addr_d  = d_addr;
                    we_d    = d_we;
                    wdata_d = d_wdata;
                    m_req_d = 1'b1;
                    state_d = BUSY_D;
                end else if (if_pend) begin
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                    m_req_d = 1'b1;
                    state_d = BUSY_I;
                end
            end
            BUSY_I: begin
                if (m_ack) begin
                    if_rdata_d = m_rdata;
                    if_valid_d = 1'b1;
                    m_req_d    = 1'b0;
                    state_d    = IDLE;
                end
            end
            BUSY_D: begin
                if (m_ack) begin
                    if (!we_q) begin
                        d_rdata_d = m_rdata;
                    end
                    d_valid_d = 1'b1;
                    m_req_d   = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                m_req_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            m_req_q    <= 1'b0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            m_req_q    <= m_req_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Fetch loses a cycle when data owns the memory or is about to be granted over it.
    assign cont_inc = if_req & ((state_q == BUSY_D) | ((state_q == IDLE) & d_req));

    sat_counter #(
        .Width (CntW),
        .Max   (CNT_MAX)
    ) u_cont_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (cont_inc),
        .cnt_o (contention_cnt)
    );

    assign m_req    = m_req_q;
    assign m_we     = we_q;
    assign m_addr   = addr_q;
    assign m_wdata  = wdata_q;
    assign if_rdata = if_rdata_q;
    assign if_valid = if_valid_q;
    assign d_rdata  = d_rdata_q;
    assign d_valid  = d_valid_q;
    assign stall_f  = if_req & ~if_valid_q;
    assign stall_m  = d_req & ~d_valid_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port if_req  input  1  instruction-fetch request; held until if_valid.
REQ-006 SHALL have port if_addr  input  ADDR_W  fetch address.
REQ-007 SHALL have port if_rdata  output  DATA_W  fetched instruction.
REQ-008 SHALL have port if_valid  output  1  one-cycle fetch completion pulse.
REQ-009 SHALL have port d_req  input  1  load/store request; held until d_valid.
REQ-010 SHALL have port d_we  input  1  1 = store (mem_write from decode), 0 = load.
REQ-011 SHALL have ports d_addr  input  ADDR_W and d_wdata  input  DATA_W  data address and store data.
REQ-012 SHALL have port d_rdata  output  DATA_W  load data.
REQ-013 SHALL have port d_valid  output  1  one-cycle data completion pulse.
REQ-014 SHALL have ports m_req  output  1, m_we  output  1, m_addr  output  ADDR_W and m_wdata  output  DATA_W  single-port memory request.
REQ-015 SHALL have ports m_rdata  input  DATA_W and m_ack  input  1  memory response, variable latency of at least 1 cycle.
REQ-016 SHALL have ports stall_f  output  1 and stall_m  output  1  stall requests to the hazard unit.
REQ-017 SHALL have port contention_cnt  output  16  count of fetch cycles lost to data priority.

Function
REQ-018 SHALL implement the FSM states IDLE, BUSY_I and BUSY_D.
REQ-019 In IDLE with d_req=1, SHALL latch d_addr, d_we and d_wdata and go to BUSY_D.
REQ-020 In IDLE with d_req=0 and if_req=1, SHALL latch if_addr, force we=0 and go to BUSY_I.
REQ-021 When if_req and d_req rise in the same cycle, data SHALL win and fetch SHALL wait; there is no round-robin.
REQ-022 In BUSY_*, m_req SHALL be 1 and m_addr, m_we and m_wdata SHALL be driven from the latched registers; m_req is registered (first asserted the cycle after grant).
REQ-023 Only one transaction SHALL be outstanding; new requests are ignored until return to IDLE.
REQ-024 On m_ack in BUSY_I, SHALL register m_rdata into if_rdata, pulse if_valid the next cycle and go to IDLE.
REQ-025 On m_ack in BUSY_D, SHALL pulse d_valid the next cycle and go to IDLE; d_rdata SHALL be updated only for loads, and stores leave it unchanged.
REQ-026 if_rdata and d_rdata SHALL hold their value until the next completion of their own kind.
REQ-027 Minimum latency from request to valid SHALL be 3 cycles (grant, m_req with m_ack in the same cycle, valid).
REQ-028 m_ack outside BUSY_* SHALL be ignored.
REQ-029 A request withdrawn mid-transaction SHALL still complete on memory; the valid pulse still occurs.
REQ-030 stall_f SHALL be combinational: if_req & ~if_valid.
REQ-031 stall_m SHALL be combinational: d_req & ~d_valid.
REQ-032 contention_cnt SHALL increment each cycle that if_req=1 while state=BUSY_D, or while in IDLE with d_req=1.
REQ-033 contention_cnt SHALL saturate at 16'hFFFF.
REQ-034 In the cycle a valid pulses, the FSM SHALL already be in IDLE and able to grant the next request.

Reset
REQ-035 While rst=1, the FSM SHALL be in IDLE regardless of clk.
REQ-036 While rst=1, m_req, if_valid, d_valid and contention_cnt SHALL be 0, and if_rdata, d_rdata and the latched address/data SHALL be 0.
REQ-037 Reset mid-transaction SHALL drop m_req immediately without waiting for m_ack; a late m_ack after reset SHALL be ignored.

Structure
REQ-038 The shared package SHALL hold the state enum (IDLE, BUSY_I, BUSY_D) and the saturation constant CNT_MAX.
REQ-039 The saturating counter SHALL be one sub-module, sat_counter, parameterised by width.

Verification
REQ-040 Fetch alone, memory ack 1 cycle after m_req: if_req=1, if_addr=0x100, m_rdata=0x00000013 -> m_req at cycle 1, if_valid pulses at cycle 3 with if_rdata=0x13.
REQ-041 Simultaneous if_req and d_req (load, d_addr=0x2000): d_addr appears on m_addr first, d_valid pulses, then fetch is granted; contention_cnt=3 with 1-cycle memory.
REQ-042 Store d_we=1, d_wdata=0xDEADBEEF: m_we=1 and m_wdata=0xDEADBEEF during m_req; d_rdata keeps its previous load value.
REQ-043 Memory latency 5 cycles: m_req holds 5 cycles, stall_f stays high throughout, and exactly one valid pulse occurs.
REQ-044 rst asserted in BUSY_D before m_ack: m_req=0 in the same cycle, an m_ack arriving afterwards produces no valid pulse, and the FSM is in IDLE.
REQ-045 Preload contention_cnt to 0xFFFE via long data traffic with fetch pending: the counter stops at 0xFFFF.
